// File: rtl/hb_pkg.sv
// hb_pkg: shared halfband width defaults and signed saturation helper
package hb_pkg;
   localparam int HB_N_CH = 2;
   localparam int HB_IN_W = 10;
   localparam int HB_COEF_W = 10;
   localparam int HB_OUT_W = 18;
   localparam int HB_DEPTH = 5;
   localparam int HB_MAX_W = 64;
   function automatic logic signed [HB_MAX_W-1:0] sat_s(input logic signed [HB_MAX_W-1:0] v, input int w);
      logic signed [HB_MAX_W-1:0] hi, lo;
      hi = $signed((HB_MAX_W'(1) << (w - 1)) - HB_MAX_W'(1));
      lo = ~hi;
      return v > hi ? hi : v < lo ? lo : v;
   endfunction
endpackage

// File: rtl/hb_sat_mul.sv
// hb_sat_mul: full-precision signed multiply clamped to OUT_W with overflow flag
module hb_sat_mul import hb_pkg::*; #(
   parameter int IN_W = HB_IN_W,
   parameter int COEF_W = HB_COEF_W,
   parameter int OUT_W = HB_OUT_W
) (
   input  logic signed [IN_W-1:0]   a,
   input  logic signed [COEF_W-1:0] c,
   output logic signed [OUT_W-1:0]  p,
   output logic                     sat
);
   localparam int PW = IN_W + COEF_W;
   logic signed [PW-1:0] prod;
   logic signed [HB_MAX_W-1:0] wide, clip;
   assign prod = PW'(a) * PW'(c);
   assign wide = HB_MAX_W'(prod);
   assign clip = sat_s(wide, OUT_W);
   assign p = clip[OUT_W-1:0];
   assign sat = clip != wide;
endmodule

// File: rtl/hb_ctap_decim.sv
// hb_ctap_decim: halfband center-tap branch, optional 2:1 decimation and delay line
module hb_ctap_decim import hb_pkg::*; #(
   parameter int N_CH = HB_N_CH,
   parameter int IN_W = HB_IN_W,
   parameter int COEF_W = HB_COEF_W,
   parameter int OUT_W = HB_OUT_W,
   parameter int DEPTH = HB_DEPTH,
   parameter int DECIM = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [N_CH*IN_W-1:0]   in_data,
   input  logic [COEF_W-1:0]      coef,
   input  logic                   flush,
   output logic                   out_valid,
   output logic [N_CH*OUT_W-1:0]  out_data,
   output logic [N_CH-1:0]        sat
);
   localparam int FW = $clog2(DEPTH + 1);
   logic [N_CH*OUT_W-1:0] m_data;
   logic [N_CH-1:0] m_sat;
   logic [DEPTH-1:0][N_CH*OUT_W-1:0] d_data;
   logic [DEPTH-1:0][N_CH-1:0] d_sat;
   logic [FW-1:0] fill;
   logic phase, full, accept;
   assign full = fill == FW'(DEPTH);
   assign accept = in_valid && !flush && (DECIM == 0 || !phase);
   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      hb_sat_mul #(.IN_W(IN_W), .COEF_W(COEF_W), .OUT_W(OUT_W)) u_mul (
         .a(in_data[i*IN_W +: IN_W]),
         .c(coef),
         .p(m_data[i*OUT_W +: OUT_W]),
         .sat(m_sat[i])
      );
   end
   // output taps the oldest stage before the shift, so only fully resident samples are flagged valid
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         phase <= 1'b0;
         fill <= '0;
         d_data <= '0;
         d_sat <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         sat <= '0;
      end else if (flush) begin
         phase <= 1'b0;
         fill <= '0;
         d_data <= '0;
         d_sat <= '0;
         out_valid <= 1'b0;
         out_data <= '0;
         sat <= '0;
      end else begin
         phase <= phase ^ in_valid;
         out_valid <= accept && full;
         if (accept) begin
            out_data <= d_data[DEPTH-1];
            sat <= d_sat[DEPTH-1];
            d_data[0] <= m_data;
            d_sat[0] <= m_sat;
            for (int k = 1; k < DEPTH; k++) begin
               d_data[k] <= d_data[k-1];
               d_sat[k] <= d_sat[k-1];
            end
            if (!full) fill <= fill + 1'b1;
         end
      end
endmodule

// File: tb/tb_hb_ctap_decim.sv
// tb_hb_ctap_decim: random and directed stimulus on both decimation modes against a sample-history model
module tb_hb_ctap_decim;
   localparam int NC = 2;
   localparam int IW = 10;
   localparam int CW = 10;
   localparam int OW = 18;
   localparam int DEP = 5;
   logic clk, rst, in_valid, flush;
   logic [NC*IW-1:0] in_data;
   logic [CW-1:0] coef;
   logic ov0, ov1;
   logic [NC*OW-1:0] od0, od1;
   logic [NC-1:0] os0, os1;
   int n_chk, n_err;
   logic [NC*OW+NC-1:0] hist [2][4096];
   int n_acc [2];
   int n_val [2];
   logic exp_v [2];
   logic [NC*OW-1:0] exp_d [2];
   logic [NC-1:0] exp_s [2];

   hb_ctap_decim #(.N_CH(NC), .IN_W(IW), .COEF_W(CW), .OUT_W(OW), .DEPTH(DEP), .DECIM(0)) u_dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .coef(coef), .flush(flush),
      .out_valid(ov0), .out_data(od0), .sat(os0)
   );
   hb_ctap_decim #(.N_CH(NC), .IN_W(IW), .COEF_W(CW), .OUT_W(OW), .DEPTH(DEP), .DECIM(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .coef(coef), .flush(flush),
      .out_valid(ov1), .out_data(od1), .sat(os1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [NC*OW+NC-1:0] model_entry(input logic [NC*IW-1:0] din, input logic [CW-1:0] c);
      logic [NC*OW+NC-1:0] r;
      longint x, p, hi, lo;
      r = '0;
      hi = (longint'(1) << (OW - 1)) - 1;
      lo = -hi - 1;
      for (int ch = 0; ch < NC; ch++) begin
         x = longint'($signed(din[ch*IW +: IW]));
         p = x * longint'($signed(c));
         r[ch*OW +: OW] = p > hi ? OW'(hi) : p < lo ? OW'(lo) : OW'(p);
         r[NC*OW + ch] = (p > hi) || (p < lo);
      end
      return r;
   endfunction

   task automatic model_clear();
      for (int d = 0; d < 2; d++) begin
         n_val[d] = 0;
         n_acc[d] = 0;
         exp_v[d] = 1'b0;
         exp_d[d] = '0;
         exp_s[d] = '0;
      end
   endtask

   task automatic model_step(input logic v, input logic [NC*IW-1:0] dat, input logic [CW-1:0] c, input logic f);
      logic acc;
      if (f) model_clear();
      else
         for (int d = 0; d < 2; d++) begin
            acc = v && (d == 0 || n_val[d] % 2 == 0);
            if (v) n_val[d]++;
            exp_v[d] = 1'b0;
            if (acc) begin
               {exp_s[d], exp_d[d]} = n_acc[d] >= DEP ? hist[d][n_acc[d]-DEP] : '0;
               exp_v[d] = n_acc[d] >= DEP;
               hist[d][n_acc[d]] = model_entry(dat, c);
               n_acc[d]++;
            end
         end
   endtask

   task automatic compare_all();
      check("valid_d0", 64'(ov0), 64'(exp_v[0]));
      check("data_d0", 64'(od0), 64'(exp_d[0]));
      check("sat_d0", 64'(os0), 64'(exp_s[0]));
      check("valid_d1", 64'(ov1), 64'(exp_v[1]));
      check("data_d1", 64'(od1), 64'(exp_d[1]));
      check("sat_d1", 64'(os1), 64'(exp_s[1]));
   endtask

   task automatic step(input logic v, input logic [NC*IW-1:0] dat, input logic [CW-1:0] c, input logic f);
      @(negedge clk);
      in_valid = v;
      in_data = dat;
      coef = c;
      flush = f;
      model_step(v, dat, c, f);
      @(posedge clk);
      #1 compare_all();
   endtask

   task automatic do_arst();
      @(posedge clk);
      #3;
      rst = 1'b1;
      in_valid = 1'b0;
      flush = 1'b0;
      model_clear();
      #1 compare_all();
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic logic [NC*IW-1:0] rnd_data();
      return NC*IW'($urandom);
   endfunction

   initial begin
      logic [CW-1:0] c;
      n_chk = 0;
      n_err = 0;
      rst = 1'b1;
      in_valid = 1'b0;
      in_data = '0;
      coef = '0;
      flush = 1'b0;
      model_clear();
      repeat (2) @(negedge clk);
      compare_all();
      rst = 1'b0;
      for (int i = 1; i <= 16; i++) step(1'b1, {10'd0, 10'(i)}, 10'd256, 1'b0);
      repeat (3) step(1'b0, '0, 10'd256, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, {10'h200, 10'h1ff}, 10'd511, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, {10'h1ff, 10'h200}, 10'h200, 1'b0);
      c = CW'($urandom);
      for (int i = 0; i < 40; i++) begin
         if (i % 8 == 0) c = CW'($urandom);
         step(1'b1, rnd_data(), c, 1'b0);
      end
      for (int i = 0; i < 150; i++) begin
         if (i % 25 == 0) c = CW'($urandom);
         step($urandom_range(0, 99) < 30, rnd_data(), c, 1'b0);
      end
      step(1'b0, '0, c, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, rnd_data(), c, 1'b0);
      step(1'b1, rnd_data(), c, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, rnd_data(), c, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, rnd_data(), c, 1'b0);
      do_arst();
      for (int i = 0; i < 16; i++) step(1'b1, rnd_data(), c, 1'b0);
      for (int i = 0; i < 40; i++) step($urandom_range(0, 99) < 50, rnd_data(), c, $urandom_range(0, 99) < 5);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
